// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode codes, burst FSM states
// and the burst-mode classifier.
package usr_pkg;

    localparam logic [2:0] USR_HOLD = 3'd0;
    localparam logic [2:0] USR_SHR  = 3'd1;
    localparam logic [2:0] USR_SHL  = 3'd2;
    localparam logic [2:0] USR_LOAD = 3'd3;
    localparam logic [2:0] USR_ROR  = 3'd4;
    localparam logic [2:0] USR_ROL  = 3'd5;
    localparam logic [2:0] USR_ASR  = 3'd6;
    localparam logic [2:0] USR_CLR  = 3'd7;

    typedef enum logic [0:0] {
        USR_IDLE = 1'b0,
        USR_BUSY = 1'b1
    } usr_state_e;

    function automatic logic is_burst_mode(input logic [2:0] mode);
        logic burst_s;
        case (mode)
            USR_SHR, USR_SHL, USR_ROR, USR_ROL, USR_ASR: burst_s = 1'b1;
            default:                                     burst_s = 1'b0;
        endcase
        return burst_s;
    endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst sequencer: IDLE/BUSY FSM with a remaining-shift down-counter. Produces the
// mode applied on each edge, a shift enable, and the busy/done handshake.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] shift_cnt,
    output logic             busy,
    output logic             done,
    output logic             shift_en,
    output logic [2:0]       eff_mode
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    usr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             done_q, done_d;

    // Next-state, counter and per-edge operation selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        shift_en = 1'b1;
        eff_mode = mode;
        case (state_q)
            USR_IDLE: begin
                if (start && is_burst_mode(mode)) begin
                    mode_d = mode;
                    if (shift_cnt == CNT_ZERO) begin
                        // Zero-length burst: register held, completion still reported.
                        shift_en = 1'b0;
                        done_d   = 1'b1;
                    end else if (shift_cnt == CNT_ONE) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = USR_BUSY;
                        cnt_d   = shift_cnt - CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            USR_BUSY: begin
                eff_mode = mode_q;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = USR_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = USR_BUSY;
                end
            end
            default: begin
                state_d  = USR_IDLE;
                cnt_d    = CNT_ZERO;
                shift_en = 1'b0;
            end
        endcase
    end

    // FSM, count, latched mode and done registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= USR_IDLE;
            cnt_q   <= CNT_ZERO;
            mode_q  <= USR_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == USR_BUSY);
    assign done = done_q;

endmodule

// File: rtl/param_universal_shift_reg.sv
// Universal shift register with burst engine. Defining USR_PARITY_EN adds a registered
// parity_out that tracks the XOR reduction of data_out.
module param_universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_cnt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             msb_in,
    input  logic             lsb_in,
    output logic [WIDTH-1:0] data_out,
`ifdef USR_PARITY_EN
    output logic             parity_out,
`endif
    output logic             msb_out,
    output logic             lsb_out,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             shift_en_s;
    logic [2:0]       eff_mode_s;

    usr_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .shift_cnt (shift_cnt),
        .busy      (busy),
        .done      (done),
        .shift_en  (shift_en_s),
        .eff_mode  (eff_mode_s)
    );

    // Next-value multiplexer over the eight operations.
    always_comb begin
        data_d = data_q;
        if (shift_en_s) begin
            case (eff_mode_s)
                USR_HOLD: data_d = data_q;
                USR_SHR:  data_d = {msb_in, data_q[WIDTH-1:1]};
                USR_SHL:  data_d = {data_q[WIDTH-2:0], lsb_in};
                USR_LOAD: data_d = data_in;
                USR_ROR:  data_d = {data_q[0], data_q[WIDTH-1:1]};
                USR_ROL:  data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                USR_ASR:  data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                USR_CLR:  data_d = {WIDTH{1'b0}};
                default:  data_d = data_q;
            endcase
        end else begin
            data_d = data_q;
        end
    end

    // Data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= {WIDTH{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

`ifdef USR_PARITY_EN
    logic parity_q;

    // Parity is computed from the value being written so it never lags data_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_d;
        end
    end

    assign parity_out = parity_q;
`endif

    assign data_out = data_q;
    assign msb_out  = data_q[WIDTH-1];
    assign lsb_out  = data_q[0];

endmodule
